// File: rtl/ql_bram_preload_ctrl.sv
// Preload sequencer for the two BRAM halves: holds the clock-mux selects steady
// around a streamed write burst and drives a registered write port.
module ql_bram_preload_ctrl #(
    parameter int DATA_W       = 18,
    parameter int ADDR_W       = 10,
    parameter int GUARD_CYCLES = 2
) (
    input  logic              PL_CLK_i,
    input  logic              RESET_i,
    input  logic              START_i,
    input  logic [1:0]        LOAD_SEL_i,
    input  logic              ABORT_i,
    input  logic [DATA_W-1:0] PL_DATA_i,
    input  logic              PL_VALID_i,
    output logic              PL_READY_o,
    output logic              preload1,
    output logic              preload2,
    output logic [ADDR_W-1:0] PL_ADDR_o,
    output logic [DATA_W-1:0] PL_DATA_o,
    output logic              PL_WEN1_o,
    output logic              PL_WEN2_o,
    output logic              BUSY_o,
    output logic              DONE_o,
    output logic              ERR_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOAD1 = 3'd2;
    localparam logic [2:0] S_LOAD2 = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [GW-1:0]     guard;

    logic guard_last;
    logic loading;
    logic abortable;
    logic take_abort;
    logic start_ok;
    logic handshake;
    logic last_word;

    assign guard_last = (guard == GUARD_LAST);
    assign loading    = (state == S_LOAD1) || (state == S_LOAD2);
    assign abortable  = (state == S_SETUP) || loading;
    assign take_abort = abortable && ABORT_i;
    assign start_ok   = (state == S_IDLE) && START_i && (LOAD_SEL_i != 2'b00);

    // Ready drops combinationally on abort so no word slips in that cycle
    assign PL_READY_o = loading && !ABORT_i;
    assign handshake  = PL_READY_o && PL_VALID_i;
    assign last_word  = handshake && (&addr);

    assign BUSY_o = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (take_abort) begin
                    state_nxt = S_HOLD;
                end else if (guard_last) begin
                    state_nxt = sel[0] ? S_LOAD1 : S_LOAD2;
                end
            end
            S_LOAD1: begin
                if (take_abort) begin
                    state_nxt = S_HOLD;
                end else if (last_word) begin
                    state_nxt = sel[1] ? S_LOAD2 : S_HOLD;
                end
            end
            S_LOAD2: begin
                if (take_abort || last_word) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (guard_last) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PL_CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            state <= S_IDLE;
            guard <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                guard <= '0;
            end else if ((state == S_SETUP) || (state == S_HOLD)) begin
                guard <= guard + GW'(1);
            end
        end
    end

    // Session bookkeeping: latched select, write address and sticky abort flag
    always_ff @(posedge PL_CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            sel   <= 2'b00;
            addr  <= '0;
            ERR_o <= 1'b0;
        end else begin
            if (start_ok) begin
                sel   <= LOAD_SEL_i;
                addr  <= '0;
                ERR_o <= 1'b0;
            end else begin
                if (handshake) begin
                    addr <= addr + ADDR_W'(1);
                end
                if (take_abort) begin
                    ERR_o <= 1'b1;
                end
            end
        end
    end

    // Selects are registered so the clock mux never sees decode glitches
    always_ff @(posedge PL_CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            preload1 <= 1'b0;
            preload2 <= 1'b0;
            DONE_o   <= 1'b0;
        end else begin
            DONE_o <= (state == S_HOLD) && guard_last && !ERR_o;
            if (start_ok) begin
                preload1 <= LOAD_SEL_i[0];
                preload2 <= LOAD_SEL_i[1];
            end else if (state == S_FIN) begin
                preload1 <= 1'b0;
                preload2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge PL_CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            PL_ADDR_o <= '0;
            PL_DATA_o <= '0;
            PL_WEN1_o <= 1'b0;
            PL_WEN2_o <= 1'b0;
        end else begin
            PL_WEN1_o <= handshake && (state == S_LOAD1);
            PL_WEN2_o <= handshake && (state == S_LOAD2);
            if (handshake) begin
                PL_ADDR_o <= addr;
                PL_DATA_o <= PL_DATA_i;
            end
        end
    end

endmodule

// File: tb/tb_ql_bram_preload_ctrl.sv
// Directed bench for ql_bram_preload_ctrl with a 16-word half and two guard cycles.
module tb_ql_bram_preload_ctrl;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 4;
    localparam int GUARD  = 2;

    localparam logic [DATA_W-1:0] D0 = 18'h15500;
    localparam logic [DATA_W-1:0] D1 = 18'h15501;
    localparam logic [DATA_W-1:0] D2 = 18'h15502;
    localparam logic [DATA_W-1:0] D3 = 18'h15503;
    localparam logic [DATA_W-1:0] D4 = 18'h15504;
    localparam logic [DATA_W-1:0] D5 = 18'h15505;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        load_sel = 2'b00;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic              preload1;
    logic              preload2;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              wen1;
    logic              wen2;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic              err_prev;

    // flags = {ready, preload1, preload2, wen1, wen2, busy, done, err}
    typedef struct {
        logic              start;
        logic [1:0]        sel;
        logic              abort;
        logic              valid;
        logic [DATA_W-1:0] din;
        logic [7:0]        flags;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dout;
    } vec_t;

    vec_t vecs[23];

    ql_bram_preload_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .PL_CLK_i(clk),
        .RESET_i(rst),
        .START_i(start),
        .LOAD_SEL_i(load_sel),
        .ABORT_i(abort),
        .PL_DATA_i(din),
        .PL_VALID_i(valid),
        .PL_READY_o(ready),
        .preload1(preload1),
        .preload2(preload2),
        .PL_ADDR_o(addr),
        .PL_DATA_o(dout),
        .PL_WEN1_o(wen1),
        .PL_WEN2_o(wen2),
        .BUSY_o(busy),
        .DONE_o(done),
        .ERR_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flags();
        return {ready, preload1, preload2, wen1, wen2, busy, done, err};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later
    task automatic apply_stimulus(input logic s, input logic [1:0] sel, input logic ab,
                                  input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk);
        start    = s;
        load_sel = sel;
        abort    = ab;
        valid    = v;
        din      = d;
        #1;
    endtask

    task automatic run_session(input logic [1:0] sel, input bit toggle, input int reset_row);
        int words;
        int hlast;
        int done_row;
        int acc;
        int idx_prev;
        bit hs_prev;
        words    = (sel == 2'b11) ? 32 : 16;
        hlast    = toggle ? (1 + 2 * words) : (2 + words);
        done_row = hlast + 3;
        acc      = 0;
        idx_prev = 0;
        hs_prev  = 1'b0;
        for (int k = 0; k <= done_row + 2; k++) begin
            logic       v;
            logic       hs;
            logic       in_win;
            logic       half2;
            logic [7:0] exp;
            v      = (k >= 1) && (toggle ? k[0] : 1'b1);
            hs     = v && (k >= 3) && (k <= hlast);
            in_win = (k >= 1) && (k <= done_row);
            half2  = (sel == 2'b10) || ((sel == 2'b11) && (idx_prev >= 16));
            apply_stimulus(k == 0, sel, 1'b0, v, DATA_W'(acc));
            if (hs_prev) begin
                last_addr = ADDR_W'(idx_prev % 16);
                last_data = DATA_W'(idx_prev);
            end
            exp = {(k >= 3) && (k <= hlast), sel[0] && in_win, sel[1] && in_win,
                   hs_prev && !half2, hs_prev && half2, in_win, k == done_row,
                   (k == 0) ? err_prev : 1'b0};
            check_output($sformatf("sel%0b flags row %0d", sel, k), 32'(flags()), 32'(exp));
            check_output($sformatf("sel%0b addr row %0d", sel, k), 32'(addr), 32'(last_addr));
            check_output($sformatf("sel%0b data row %0d", sel, k), 32'(dout), 32'(last_data));
            hs_prev  = hs;
            idx_prev = acc;
            if (hs) acc++;
            if (k == reset_row) begin
                #2 rst = 1'b1;
                #1;
                check_output("async reset flags", 32'(flags()), 32'h0);
                check_output("async reset addr", 32'(addr), 32'h0);
                check_output("async reset data", 32'(dout), 32'h0);
                @(negedge clk);
                rst       = 1'b0;
                valid     = 1'b0;
                last_addr = '0;
                last_data = '0;
                err_prev  = 1'b0;
                return;
            end
        end
        valid    = 1'b0;
        err_prev = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, '0, 8'b00000000, 4'd0, '0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b00000000, 4'd0, '0};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, '0, 8'b00000000, 4'd0, '0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 1'b0, '0, 8'b01000100, 4'd0, '0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, D0, 8'b01000100, 4'd0, '0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, D0, 8'b11000100, 4'd0, '0};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, D1, 8'b11010100, 4'd0, D0};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, D2, 8'b11010100, 4'd1, D1};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 1'b1, D3, 8'b11010100, 4'd2, D2};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, D4, 8'b11010100, 4'd3, D3};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b1, D5, 8'b01010100, 4'd4, D4};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, D5, 8'b01000101, 4'd4, D4};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b1, D5, 8'b01000101, 4'd4, D4};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b01000101, 4'd4, D4};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b00000001, 4'd4, D4};
        vecs[15] = '{1'b1, 2'b01, 1'b0, 1'b0, '0, 8'b00000001, 4'd4, D4};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b01000100, 4'd4, D4};
        vecs[17] = '{1'b0, 2'b00, 1'b1, 1'b0, '0, 8'b01000100, 4'd4, D4};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b01000101, 4'd4, D4};
        vecs[19] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b01000101, 4'd4, D4};
        vecs[20] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b01000101, 4'd4, D4};
        vecs[21] = '{1'b0, 2'b00, 1'b1, 1'b0, '0, 8'b00000001, 4'd4, D4};
        vecs[22] = '{1'b0, 2'b00, 1'b0, 1'b0, '0, 8'b00000001, 4'd4, D4};

        #2;
        check_output("reset flags", 32'(flags()), 32'h0);
        check_output("reset addr", 32'(addr), 32'h0);
        check_output("reset data", 32'(dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].sel, vecs[i].abort, vecs[i].valid, vecs[i].din);
            check_output($sformatf("vec %0d flags", i), 32'(flags()), 32'(vecs[i].flags));
            check_output($sformatf("vec %0d addr", i), 32'(addr), 32'(vecs[i].addr));
            check_output($sformatf("vec %0d data", i), 32'(dout), 32'(vecs[i].dout));
        end
        abort     = 1'b0;
        last_addr = 4'd4;
        last_data = D4;
        err_prev  = 1'b1;

        run_session(2'b01, 1'b0, -1);
        run_session(2'b11, 1'b1, -1);
        run_session(2'b11, 1'b0, -1);
        run_session(2'b11, 1'b0, 25);
        run_session(2'b10, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
